// File: rtl/motion_update_writeback_if.sv
// Particle stream in, per-cell cache write commands and pass status out.
interface motion_update_writeback_if #(
    parameter int unsigned OFFSET_WIDTH      = 29,
    parameter int unsigned DATA_WIDTH        = 32,
    parameter int unsigned PARTICLE_ID_WIDTH = 7,
    parameter int unsigned CELL_ID_WIDTH     = 3,
    parameter int unsigned NUM_CELLS         = 64
);
    localparam int unsigned POS_CACHE_WIDTH      = 3 * OFFSET_WIDTH;
    localparam int unsigned VELOCITY_CACHE_WIDTH = 3 * DATA_WIDTH;

    logic                                     motion_update_start;
    logic                                     in_data_valid;
    logic [3*CELL_ID_WIDTH-1:0]               in_dst_cell;
    logic [POS_CACHE_WIDTH-1:0]               in_position_data;
    logic [VELOCITY_CACHE_WIDTH-1:0]          in_velocity_data;
    logic                                     in_motion_update_done;

    logic [NUM_CELLS-1:0]                     out_wr_enable;
    logic [PARTICLE_ID_WIDTH-1:0]             out_wr_addr;
    logic [POS_CACHE_WIDTH-1:0]               out_position_data;
    logic [VELOCITY_CACHE_WIDTH-1:0]          out_velocity_data;
    logic [NUM_CELLS*PARTICLE_ID_WIDTH-1:0]   out_particle_count;
    logic [NUM_CELLS-1:0]                     out_overflow;
    logic                                     out_dst_error;
    logic                                     out_busy;
    logic                                     out_writeback_done;

    modport master (
        output motion_update_start, in_data_valid, in_dst_cell,
               in_position_data, in_velocity_data, in_motion_update_done,
        input  out_wr_enable, out_wr_addr, out_position_data, out_velocity_data,
               out_particle_count, out_overflow, out_dst_error, out_busy,
               out_writeback_done
    );

    modport slave (
        input  motion_update_start, in_data_valid, in_dst_cell,
               in_position_data, in_velocity_data, in_motion_update_done,
        output out_wr_enable, out_wr_addr, out_position_data, out_velocity_data,
               out_particle_count, out_overflow, out_dst_error, out_busy,
               out_writeback_done
    );
endinterface

// File: rtl/motion_update_writeback.sv
// Turns the serial stream of updated particles into per-cell cache writes,
// handing each particle the next free slot of its destination cell.
module motion_update_writeback #(
    parameter int unsigned OFFSET_WIDTH      = 29,
    parameter int unsigned DATA_WIDTH        = 32,
    parameter int unsigned PARTICLE_ID_WIDTH = 7,
    parameter int unsigned CELL_ID_WIDTH     = 3,
    parameter int unsigned NUM_CELLS         = 64,
    parameter int unsigned X_DIM             = 4,
    parameter int unsigned Y_DIM             = 4,
    parameter int unsigned Z_DIM             = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    motion_update_writeback_if.slave  bus
);
    localparam int unsigned POS_W   = 3 * OFFSET_WIDTH;
    localparam int unsigned VEL_W   = 3 * DATA_WIDTH;
    localparam int unsigned PIW     = PARTICLE_ID_WIDTH;
    localparam int unsigned CW      = CELL_ID_WIDTH;
    localparam int unsigned IDX_W   = $clog2(NUM_CELLS);
    localparam int unsigned CNT_W   = NUM_CELLS * PIW;
    localparam logic [CW-1:0]  X_MAX   = CW'(X_DIM);
    localparam logic [CW-1:0]  Y_MAX   = CW'(Y_DIM);
    localparam logic [CW-1:0]  Z_MAX   = CW'(Z_DIM);
    localparam logic [PIW-1:0] CNT_TOP = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACTIVE,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t               state_q, state_d;
    logic                 accept;

    logic [CW-1:0]        cx, cy, cz;
    logic                 legal;
    logic [IDX_W-1:0]     cell_idx;
    logic [NUM_CELLS-1:0] cell_onehot;
    logic [PIW-1:0]       cur_count;

    logic [NUM_CELLS-1:0] wr_enable_q;
    logic [PIW-1:0]       wr_addr_q;
    logic [POS_W-1:0]     pos_q;
    logic [VEL_W-1:0]     vel_q;
    logic [CNT_W-1:0]     count_q;
    logic [NUM_CELLS-1:0] full_q;
    logic [NUM_CELLS-1:0] overflow_q;
    logic                 dst_error_q;
    logic                 busy_q;
    logic                 done_q;

    // Destination decode: 1-based {z,y,x} to linear cell index
    always_comb begin
        cx = bus.in_dst_cell[0 +: CW];
        cy = bus.in_dst_cell[CW +: CW];
        cz = bus.in_dst_cell[2*CW +: CW];
        legal = (cx != '0) && (cx <= X_MAX) &&
                (cy != '0) && (cy <= Y_MAX) &&
                (cz != '0) && (cz <= Z_MAX);
        cell_idx = IDX_W'(((32'(cz) - 32'd1) * Y_DIM + (32'(cy) - 32'd1)) * X_DIM
                          + (32'(cx) - 32'd1));
        cell_onehot = '0;
        cell_onehot[cell_idx] = 1'b1;
        cur_count = count_q[cell_idx*PIW +: PIW];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Start restarts the pass from any state and swallows a same-cycle valid
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        if (bus.motion_update_start) begin
            state_d = S_ACTIVE;
        end else begin
            case (state_q)
                S_IDLE:   state_d = S_IDLE;
                S_ACTIVE: begin
                    accept = bus.in_data_valid;
                    if (bus.in_motion_update_done) state_d = S_DRAIN;
                end
                S_DRAIN:  state_d = S_DONE;
                S_DONE:   state_d = S_IDLE;
                default:  state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_enable_q <= '0;
            wr_addr_q   <= '0;
            pos_q       <= '0;
            vel_q       <= '0;
            count_q     <= '0;
            full_q      <= '0;
            overflow_q  <= '0;
            dst_error_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            wr_enable_q <= '0;
            busy_q      <= (state_d == S_ACTIVE) || (state_d == S_DRAIN);
            done_q      <= (state_d == S_DONE);
            if (bus.motion_update_start) begin
                count_q     <= '0;
                full_q      <= '0;
                overflow_q  <= '0;
                dst_error_q <= 1'b0;
            end else if (accept) begin
                if (!legal) begin
                    dst_error_q <= 1'b1;
                end else if (full_q[cell_idx]) begin
                    overflow_q[cell_idx] <= 1'b1;
                end else begin
                    wr_enable_q <= cell_onehot;
                    wr_addr_q   <= cur_count;
                    pos_q       <= bus.in_position_data;
                    vel_q       <= bus.in_velocity_data;
                    // Last slot: write goes out, counter parks at all-ones
                    if (cur_count == CNT_TOP) full_q[cell_idx] <= 1'b1;
                    else count_q[cell_idx*PIW +: PIW] <= cur_count + PIW'(1);
                end
            end
        end
    end

    assign bus.out_wr_enable      = wr_enable_q;
    assign bus.out_wr_addr        = wr_addr_q;
    assign bus.out_position_data  = pos_q;
    assign bus.out_velocity_data  = vel_q;
    assign bus.out_particle_count = count_q;
    assign bus.out_overflow       = overflow_q;
    assign bus.out_dst_error      = dst_error_q;
    assign bus.out_busy           = busy_q;
    assign bus.out_writeback_done = done_q;
endmodule

// File: tb/tb_motion_update_writeback.sv
// Bench for motion_update_writeback: vector table, directed corner sequences
// and random traffic against a slot-counting reference model.
module tb_motion_update_writeback;
    localparam int unsigned NC    = 64;
    localparam int unsigned PIW   = 7;
    localparam int unsigned POS_W = 87;
    localparam int unsigned VEL_W = 96;
    localparam int          SLOTS = 128;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    motion_update_writeback_if bus ();

    motion_update_writeback dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: number of writes granted to each cell this pass
    int               n_wr [NC];
    int               phase;
    logic [NC-1:0]    exp_we;
    logic [PIW-1:0]   exp_addr;
    logic [POS_W-1:0] exp_pos;
    logic [VEL_W-1:0] exp_vel;
    logic [NC-1:0]    exp_ovf;
    logic             exp_err;
    logic             exp_busy;
    logic             exp_done;

    task automatic check(string name, logic [511:0] act, logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [NC*PIW-1:0] model_counts();
        logic [NC*PIW-1:0] v;
        for (int c = 0; c < NC; c++)
            v[c*PIW +: PIW] = (n_wr[c] >= SLOTS) ? 7'h7f : PIW'(n_wr[c]);
        return v;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NC; c++) n_wr[c] = 0;
        phase = 0;
        exp_we = '0; exp_addr = '0; exp_pos = '0; exp_vel = '0;
        exp_ovf = '0; exp_err = 1'b0; exp_busy = 1'b0; exp_done = 1'b0;
    endtask

    function automatic logic [8:0] mk(int x, int y, int z);
        return {3'(z), 3'(y), 3'(x)};
    endfunction

    task automatic check_all();
        check("wr_enable", bus.out_wr_enable, exp_we);
        check("wr_addr", bus.out_wr_addr, exp_addr);
        check("position", bus.out_position_data, exp_pos);
        check("velocity", bus.out_velocity_data, exp_vel);
        check("counts", bus.out_particle_count, model_counts());
        check("overflow", bus.out_overflow, exp_ovf);
        check("dst_error", bus.out_dst_error, exp_err);
        check("busy", bus.out_busy, exp_busy);
        check("wb_done", bus.out_writeback_done, exp_done);
    endtask

    // One clock of stimulus; model predicts, outputs sampled 1 time unit after the edge
    task automatic cycle(bit start, bit valid, logic [8:0] dst, bit done);
        logic [POS_W-1:0] pos;
        logic [VEL_W-1:0] vel;
        int x, y, z, c;
        pos = POS_W'({$urandom, $urandom, $urandom});
        vel = VEL_W'({$urandom, $urandom, $urandom});
        bus.motion_update_start   = start;
        bus.in_data_valid         = valid;
        bus.in_dst_cell           = dst;
        bus.in_position_data      = pos;
        bus.in_velocity_data      = vel;
        bus.in_motion_update_done = done;

        exp_we = '0;
        if (start) begin
            for (int i = 0; i < NC; i++) n_wr[i] = 0;
            exp_ovf = '0;
            exp_err = 1'b0;
            phase = 1;
        end else if (phase == 1) begin
            if (valid) begin
                x = int'(dst[2:0]); y = int'(dst[5:3]); z = int'(dst[8:6]);
                if (x < 1 || x > 4 || y < 1 || y > 4 || z < 1 || z > 4) begin
                    exp_err = 1'b1;
                end else begin
                    c = (z - 1) * 16 + (y - 1) * 4 + (x - 1);
                    if (n_wr[c] >= SLOTS) exp_ovf[c] = 1'b1;
                    else begin
                        exp_we[c] = 1'b1;
                        exp_addr = PIW'(n_wr[c]);
                        exp_pos = pos;
                        exp_vel = vel;
                        n_wr[c]++;
                    end
                end
            end
            if (done) phase = 2;
        end else if (phase == 2) phase = 3;
        else if (phase == 3) phase = 0;
        exp_busy = (phase == 1) || (phase == 2);
        exp_done = (phase == 3);

        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 9'd0, 1'b0);
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear before the next edge
    task automatic do_reset();
        rst = 1'b1;
        bus.motion_update_start = 1'b0;
        bus.in_data_valid = 1'b0;
        bus.in_motion_update_done = 1'b0;
        model_reset();
        #1;
        check_all();
        check("rst_we_zero", bus.out_wr_enable, 512'd0);
        check("rst_busy_zero", bus.out_busy, 512'd0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        bit         start;
        bit         valid;
        logic [8:0] dst;
        bit         done;
        int         we_bit;
        int         addr;
        bit         busy;
        bit         wb_done;
    } vec_t;

    vec_t tbl [11];

    initial begin
        logic [NC-1:0] w;
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.motion_update_start = 1'b0;
        bus.in_data_valid = 1'b0;
        bus.in_dst_cell = '0;
        bus.in_position_data = '0;
        bus.in_velocity_data = '0;
        bus.in_motion_update_done = 1'b0;
        model_reset();
        #2;
        check_all();
        @(negedge clk);
        rst = 1'b0;

        // Vector table: five writes to cell 0, then cells 1, 4, 63 with done
        tbl[0] = '{1, 0, mk(0, 0, 0), 0, -1, 0, 1, 0};
        for (int i = 1; i <= 5; i++) tbl[i] = '{0, 1, mk(1, 1, 1), 0, 0, i - 1, 1, 0};
        tbl[6]  = '{0, 1, mk(2, 1, 1), 0, 1, 0, 1, 0};
        tbl[7]  = '{0, 1, mk(1, 2, 1), 0, 4, 0, 1, 0};
        tbl[8]  = '{0, 1, mk(4, 4, 4), 1, 63, 0, 1, 0};
        tbl[9]  = '{0, 0, mk(0, 0, 0), 0, -1, 0, 0, 1};
        tbl[10] = '{0, 0, mk(0, 0, 0), 0, -1, 0, 0, 0};
        for (int i = 0; i < 11; i++) begin
            cycle(tbl[i].start, tbl[i].valid, tbl[i].dst, tbl[i].done);
            w = '0;
            if (tbl[i].we_bit >= 0) begin
                w[tbl[i].we_bit] = 1'b1;
                check("tbl_addr", bus.out_wr_addr, 512'(tbl[i].addr));
            end
            check("tbl_we", bus.out_wr_enable, w);
            check("tbl_busy", bus.out_busy, 512'(tbl[i].busy));
            check("tbl_done", bus.out_writeback_done, 512'(tbl[i].wb_done));
        end
        check("tbl_count0", bus.out_particle_count[0 +: PIW], 512'd5);

        // Fill cell 0 to its last slot, then one more
        cycle(1'b1, 1'b0, mk(0, 0, 0), 1'b0);
        for (int i = 0; i < SLOTS; i++) cycle(1'b0, 1'b1, mk(1, 1, 1), 1'b0);
        check("last_slot_we", bus.out_wr_enable, 512'd1);
        check("last_slot_addr", bus.out_wr_addr, 512'd127);
        cycle(1'b0, 1'b1, mk(1, 1, 1), 1'b0);
        check("ovf_no_we", bus.out_wr_enable, 512'd0);
        check("ovf_flag", bus.out_overflow, 512'd1);
        check("ovf_count", bus.out_particle_count[0 +: PIW], 512'd127);

        // Restart while active: clears counts and overflow, drops same-cycle valid
        cycle(1'b1, 1'b1, mk(2, 2, 2), 1'b0);
        check("restart_no_we", bus.out_wr_enable, 512'd0);
        check("restart_ovf", bus.out_overflow, 512'd0);
        check("restart_counts", bus.out_particle_count, 512'd0);
        cycle(1'b0, 1'b1, mk(2, 2, 2), 1'b1);
        check("final_we", bus.out_wr_enable, 512'd1 << 21);
        check("final_addr", bus.out_wr_addr, 512'd0);
        check("drain_busy", bus.out_busy, 512'd1);
        cycle(1'b0, 1'b1, mk(2, 2, 2), 1'b1);
        check("done_pulse", bus.out_writeback_done, 512'd1);
        check("drain_no_we", bus.out_wr_enable, 512'd0);
        idle(2);

        // Illegal coordinates
        cycle(1'b1, 1'b0, mk(0, 0, 0), 1'b0);
        cycle(1'b0, 1'b1, mk(0, 1, 1), 1'b0);
        check("x0_no_we", bus.out_wr_enable, 512'd0);
        cycle(1'b0, 1'b1, mk(1, 1, 5), 1'b0);
        check("z5_no_we", bus.out_wr_enable, 512'd0);
        check("dst_err", bus.out_dst_error, 512'd1);
        check("err_counts", bus.out_particle_count, 512'd0);

        // Reset in the middle of a pass, then valids without a start
        cycle(1'b1, 1'b0, mk(0, 0, 0), 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, mk(3, 2, 1), 1'b0);
        do_reset();
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b1, mk(3, 2, 1), 1'b1);
            check("post_rst_ignored", bus.out_wr_enable, 512'd0);
        end

        // Random traffic over a few cells with occasional illegal, done and start
        cycle(1'b1, 1'b0, mk(0, 0, 0), 1'b0);
        for (int i = 0; i < 600; i++) begin
            int x, y, z;
            x = int'($urandom_range(1, 2));
            y = int'($urandom_range(1, 2));
            z = int'($urandom_range(1, 4));
            if ($urandom_range(0, 19) == 0) x = ($urandom_range(0, 1) == 0) ? 0 : 5;
            cycle($urandom_range(0, 79) == 0, $urandom_range(0, 9) < 7,
                  mk(x, y, z), $urandom_range(0, 49) == 0);
        end
        idle(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
